// File: rtl/tt_um_jimktrains_vslc_scan_ctrl.sv
// Scan controller: decodes the program header, sequences RUN/WAIT/RESTART scans and flags trigger overruns.
// Optional overrun counter enabled by defining VSLC_SCAN_OVR_CNT_EN.
module tt_um_jimktrains_vslc_scan_ctrl #(
    parameter int ADDR_W = 10,
    parameter int N_IN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_ready,
    input  logic [7:0]        rd_byte,
    input  logic [15:0]       rd_addr,
    input  logic              mode_auto,
    input  logic              trig_in,
    input  logic              clr_ovr,
    input  logic [N_IN-1:0]   in_pins,
    output logic              restart,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr,
    output logic              instr_ready,
    output logic [N_IN-1:0]   in_cur,
    output logic [N_IN-1:0]   in_prev,
    output logic              scan_pulse,
    output logic              overrun,
    output logic [7:0]        ovr_cnt,
    output logic [2:0]        state
);

    localparam logic [2:0] ST_HDR     = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_RESTART = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;
    localparam int         HI_W       = ADDR_W - 8;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] end_addr_q, end_addr_d;
    logic [N_IN-1:0]   in_cur_q, in_cur_d;
    logic [N_IN-1:0]   in_prev_q, in_prev_d;
    logic              scan_pulse_q, scan_pulse_d;
    logic              overrun_q, overrun_d;
    logic [2:0]        trig_q, trig_d;
    logic              trig_edge;
    logic              ovr_evt;
    logic [ADDR_W-1:0] end_dec;
    logic [15:0]       end_ext;

    // trig_q[1:0] is the two-flop synchroniser; trig_q[2] holds the previous synchronised value.
    always_comb begin
        trig_d    = {trig_q[1:0], trig_in};
        trig_edge = trig_q[1] & ~trig_q[2];
        ovr_evt   = trig_edge && ((state_q == ST_RUN) || (state_q == ST_RESTART));
        overrun_d = ovr_evt | (overrun_q & ~clr_ovr);
        end_dec   = {end_addr_q[ADDR_W-1:8], rd_byte};
        end_ext   = 16'(end_addr_q);
    end

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        in_cur_d     = in_cur_q;
        in_prev_d    = in_prev_q;
        case (state_q)
            ST_HDR: begin
                if (rd_ready) begin
                    case (rd_addr)
                        16'd0:   start_addr_d[ADDR_W-1:8] = rd_byte[HI_W-1:0];
                        16'd1:   start_addr_d[7:0]        = rd_byte;
                        16'd2:   end_addr_d[ADDR_W-1:8]   = rd_byte[HI_W-1:0];
                        16'd3:   end_addr_d[7:0]          = rd_byte;
                        default: ;
                    endcase
                    // The end-address low byte arrives this cycle, so judge the combined value.
                    if (rd_addr == 16'd3) begin
                        state_d = (end_dec == '0) ? ST_HALT : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (rd_ready && (rd_addr >= end_ext)) begin
                    state_d = mode_auto ? ST_RESTART : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (trig_edge) begin
                    state_d = ST_RESTART;
                end
            end
            ST_RESTART: state_d = ST_RUN;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_HDR;
        endcase
        scan_pulse_d = (state_d == ST_RUN) && (state_q != ST_RUN);
        if (scan_pulse_d) begin
            in_prev_d = in_cur_q;
            in_cur_d  = in_pins;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_HDR;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            in_cur_q     <= in_pins;
            in_prev_q    <= in_pins;
            scan_pulse_q <= 1'b0;
            overrun_q    <= 1'b0;
            trig_q       <= '0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            in_cur_q     <= in_cur_d;
            in_prev_q    <= in_prev_d;
            scan_pulse_q <= scan_pulse_d;
            overrun_q    <= overrun_d;
            trig_q       <= trig_d;
        end
    end

`ifdef VSLC_SCAN_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // A clear coinciding with a new overrun leaves that overrun counted.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (clr_ovr) begin
            ovr_cnt_d = ovr_evt ? 8'd1 : 8'd0;
        end else if (ovr_evt && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = 8'd0;
`endif

    assign state       = state_q;
    assign start_addr  = start_addr_q;
    assign end_addr    = end_addr_q;
    assign in_cur      = in_cur_q;
    assign in_prev     = in_prev_q;
    assign scan_pulse  = scan_pulse_q;
    assign overrun     = overrun_q;
    assign restart     = (state_q == ST_RESTART);
    assign instr_ready = rd_ready && (state_q == ST_RUN) && (rd_addr > 16'd3);

endmodule

// File: doc/tt_um_jimktrains_vslc_scan_ctrl.md
TT_UM_JIMKTRAINS_VSLC_SCAN_CTRL -- requirements
Module: tt_um_jimktrains_vslc_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, program address width, legal range 9..16.
REQ-002 SHALL have parameter N_IN, default 8, number of sampled input channels, legal range 1..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port rd_ready, input, 1, one-cycle strobe: rd_byte/rd_addr valid.
REQ-006 SHALL have port rd_byte, input, 8, byte delivered by the EEPROM reader.
REQ-007 SHALL have port rd_addr, input, 16, EEPROM address of rd_byte.
REQ-008 SHALL have port mode_auto, input, 1, 1 = free-running scan, 0 = externally triggered scan.
REQ-009 SHALL have port trig_in, input, 1, asynchronous external scan trigger.
REQ-010 SHALL have port clr_ovr, input, 1, clears the overrun flag.
REQ-011 SHALL have port in_pins, input, N_IN, raw input channels.
REQ-012 SHALL have port restart, output, 1, one-cycle request to restart the reader at start_addr.
REQ-013 SHALL have port start_addr and end_addr, output, ADDR_W each, header-decoded program bounds.
REQ-014 SHALL have port instr_ready, output, 1, rd_ready qualified as a program byte.
REQ-015 SHALL have port in_cur and in_prev, output, N_IN each, current and previous scan input snapshots.
REQ-016 SHALL have port scan_pulse, output, 1, one cycle on every entry to RUN.
REQ-017 SHALL have port overrun, output, 1, sticky trigger-during-scan flag.
REQ-018 SHALL have port ovr_cnt, output, 8, overrun counter.
REQ-019 SHALL have port state, output, 3, encoded FSM state: HDR=0, RUN=1, WAIT=2, RESTART=3, HALT=4.

Function
REQ-020 SHALL decode the header on rd_ready: addr 0 -> start_addr[ADDR_W-1:8] = rd_byte[ADDR_W-9:0]; addr 1 -> start_addr[7:0]; addr 2/3 -> end_addr likewise; any other header bits are discarded.
REQ-021 SHALL, in HDR, on rd_ready with rd_addr==3, go to HALT if the decoded end_addr is 0, otherwise go to RUN.
REQ-022 SHALL stay in HALT until reset; restart and instr_ready remain 0.
REQ-023 SHALL drive instr_ready = rd_ready && state==RUN && rd_addr>3, combinationally, zero latency.
REQ-024 SHALL, in RUN, on rd_ready with rd_addr >= end_addr (zero-extended), go to RESTART if mode_auto=1, else to WAIT; that byte still asserts instr_ready.
REQ-025 SHALL synchronise trig_in through two flops and detect rising edges on the synchronised value (edge visible 3 cycles after pin rise).
REQ-026 SHALL, in WAIT, on a trigger edge go to RESTART; mode_auto changes take effect at the next end-of-program decision only.
REQ-027 SHALL assert restart for exactly the one cycle spent in RESTART, then enter RUN.
REQ-028 SHALL, on every entry to RUN (from HDR or RESTART), assert scan_pulse for one cycle and load in_prev <= in_cur, in_cur <= in_pins in that same edge.
REQ-029 SHALL treat a trigger edge in RUN or RESTART as overrun: set overrun, no state change; a trigger edge in HDR or HALT SHALL be ignored.
REQ-030 SHALL clear overrun on clr_ovr; a simultaneous new overrun SHALL win (flag stays 1).
REQ-031 SHALL ignore rd_ready in WAIT, RESTART and HALT.

Reset
REQ-032 SHALL, while rst_n=0 at posedge clk: state=HDR, start_addr=0, end_addr=0, restart=0, scan_pulse=0, overrun=0, ovr_cnt=0, trigger synchroniser=0, in_cur=in_prev=in_pins.
REQ-033 SHALL, on reset asserted mid-scan, abandon the scan and re-decode the header from the next rd_ready after release.

Configuration
REQ-034 SHALL, with VSLC_SCAN_OVR_CNT_EN defined, increment ovr_cnt on each overrun event, saturating at 255, cleared by clr_ovr (simultaneous event: counter = 1).
REQ-035 SHALL, without VSLC_SCAN_OVR_CNT_EN, tie ovr_cnt to 0 and instantiate no counter logic; overrun flag unaffected.

Verification
REQ-036 SHALL cover: header bytes 01,20,01,40 at addr 0..3, ADDR_W=10 -> start_addr=0x120, end_addr=0x140, state RUN, scan_pulse one cycle.
REQ-037 SHALL cover: mode_auto=1, byte at rd_addr 0x140 -> instr_ready=1 that cycle, restart=1 next cycle, RUN following, in_prev=old in_cur.
REQ-038 SHALL cover: header end bytes 00,00 -> state HALT, no restart after 100 further rd_ready strobes.
REQ-039 SHALL cover: mode_auto=0, end reached -> WAIT; trig_in rise -> restart 3-4 cycles later; second trig_in rise during RUN -> overrun=1, ovr_cnt=1 (macro on) / 0 (macro off).
REQ-040 SHALL cover: 300 overruns then clr_ovr coincident with another overrun -> before clear ovr_cnt=255; after, overrun=1, ovr_cnt=1.
REQ-041 SHALL cover: rst_n low during RUN at rd_addr 0x130 -> all REQ-032 values next cycle; fresh header 00,10,00,20 -> start_addr=0x010, end_addr=0x020.
